// File: rtl/nx_fifo_pkg.sv
// Shared defaults and helper functions for the nx FIFO slice.
package nx_fifo_pkg;

    localparam int NX_DATA_W_DEFAULT = 71;
    localparam int NX_DEPTH_DEFAULT  = 2048;

    function automatic int aw_of(input int depth);
        return $clog2(depth);
    endfunction

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic parity_of(input logic [255:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/nx_ram_1r1w_behav.sv
// Behavioural simple dual-port RAM: one write port, one read port, registered read, no reset.
module nx_ram_1r1w_behav #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/nx_fifo_ram_1r1w_fwft.sv
// RAM-backed FIFO with optional first-word-fall-through output stage and per-word parity.
module nx_fifo_ram_1r1w_fwft
    import nx_fifo_pkg::*;
#(
    parameter int DATA_W    = NX_DATA_W_DEFAULT,
    parameter int DEPTH     = NX_DEPTH_DEFAULT,
    parameter int FWFT      = 1,
    parameter int PARITY_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wen,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  err_inj,
    input  logic                  ren,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic                  rerr,
    output logic                  empty,
    output logic                  full,
    output logic [aw_of(DEPTH):0] used_slots,
    output logic [aw_of(DEPTH):0] free_slots,
    input  logic [aw_of(DEPTH):0] afull_thresh,
    input  logic [aw_of(DEPTH):0] aempty_thresh,
    output logic                  afull,
    output logic                  aempty,
    output logic                  underflow,
    output logic                  overflow,
    output logic                  parity_err_sticky
);

    localparam int AW = aw_of(DEPTH);
    localparam int WW = DATA_W + PARITY_EN;
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [AW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [AW:0]   used_q, used_d, ramCnt_q, ramCnt_d;
    logic          fetchVal_q, fetchVal_d;
    logic [WW-1:0] sk0_q, sk0_d, sk1_q, sk1_d;
    logic [1:0]    skCnt_q, skCnt_d;
    logic          afull_q, afull_d, aempty_q, aempty_d;
    logic          over_q, over_d, under_q, under_d, sticky_q, sticky_d;
    logic [WW-1:0] ramRdata, wrWord, headWord;
    logic          headValid, wAcc, rAcc, ramRe;

    nx_ram_1r1w_behav #(.WIDTH(WW), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk_i   (clk),
        .we_i    (wAcc),
        .waddr_i (wrPtr_q),
        .wdata_i (wrWord),
        .re_i    (ramRe),
        .raddr_i (rdPtr_q),
        .rdata_o (ramRdata)
    );

    // In FWFT mode the head is the oldest skid entry, else the word arriving from the RAM.
    always_comb begin
        headValid = (FWFT != 0) ? ((skCnt_q != 2'd0) || fetchVal_q) : fetchVal_q;
        headWord  = ((FWFT != 0) && (skCnt_q != 2'd0)) ? sk0_q : ramRdata;
        empty     = (FWFT != 0) ? !headValid : (used_q == '0);
        full      = (used_q == DEPTH_C);
        wAcc      = wen && !full && !clear;
        rAcc      = ren && !empty && !clear;
    end

    // A fetch is only launched when the skid is guaranteed room for it next cycle.
    always_comb begin
        sk0_d   = sk0_q;
        sk1_d   = sk1_q;
        skCnt_d = skCnt_q;
        ramRe   = 1'b0;
        if (FWFT != 0) begin
            if (rAcc && (skCnt_q != 2'd0)) begin
                sk0_d   = sk1_q;
                skCnt_d = skCnt_q - 2'd1;
            end
            if (fetchVal_q && !(rAcc && (skCnt_q == 2'd0))) begin
                if (skCnt_d == 2'd0) begin
                    sk0_d = ramRdata;
                end else begin
                    sk1_d = ramRdata;
                end
                skCnt_d = skCnt_d + 2'd1;
            end
            ramRe = (ramCnt_q != '0) && (skCnt_d < 2'd2);
        end else begin
            ramRe = rAcc;
        end
        if (clear) begin
            skCnt_d = 2'd0;
        end
    end

    always_comb begin
        wrPtr_d    = wrPtr_q + {{(AW-1){1'b0}}, wAcc};
        rdPtr_d    = rdPtr_q + {{(AW-1){1'b0}}, ramRe};
        used_d     = used_q + {{AW{1'b0}}, wAcc} - {{AW{1'b0}}, rAcc};
        ramCnt_d   = ramCnt_q + {{AW{1'b0}}, wAcc} - {{AW{1'b0}}, ramRe};
        fetchVal_d = ramRe;
        over_d     = wen && full;
        under_d    = ren && empty;
        afull_d    = (used_d >= afull_thresh);
        aempty_d   = (used_d <= aempty_thresh);
        sticky_d   = sticky_q | rerr;
        if (clear) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            used_d     = '0;
            ramCnt_d   = '0;
            fetchVal_d = 1'b0;
            over_d     = 1'b0;
            under_d    = 1'b0;
            afull_d    = 1'b0;
            aempty_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            used_q     <= '0;
            ramCnt_q   <= '0;
            fetchVal_q <= 1'b0;
            sk0_q      <= '0;
            sk1_q      <= '0;
            skCnt_q    <= 2'd0;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
            over_q     <= 1'b0;
            under_q    <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            used_q     <= used_d;
            ramCnt_q   <= ramCnt_d;
            fetchVal_q <= fetchVal_d;
            sk0_q      <= sk0_d;
            sk1_q      <= sk1_d;
            skCnt_q    <= skCnt_d;
            afull_q    <= afull_d;
            aempty_q   <= aempty_d;
            over_q     <= over_d;
            under_q    <= under_d;
            sticky_q   <= sticky_d;
        end
    end

    if (PARITY_EN != 0) begin : gParity
        logic [255:0] wExt, hExt;
        always_comb begin
            wExt = '0;
            wExt[DATA_W-1:0] = wdata;
            hExt = '0;
            hExt[DATA_W-1:0] = headWord[DATA_W-1:0];
            wrWord = {parity_of(wExt) ^ err_inj, wdata};
            rerr   = headValid && (parity_of(hExt) != headWord[WW-1]);
        end
    end else begin : gNoParity
        logic unusedErrInj;
        assign unusedErrInj = err_inj;
        assign wrWord       = wdata;
        assign rerr         = 1'b0;
    end

    assign rvalid            = headValid;
    assign rdata             = headValid ? headWord[DATA_W-1:0] : '0;
    assign used_slots        = used_q;
    assign free_slots        = DEPTH_C - used_q;
    assign afull             = afull_q;
    assign aempty            = aempty_q;
    assign overflow          = over_q;
    assign underflow         = under_q;
    assign parity_err_sticky = sticky_q;

endmodule

// File: tb/tb_nx_fifo_ram_1r1w_fwft.sv
// Directed bench: one FWFT instance and one registered-read instance driven by the same stimulus.
module tb_nx_fifo_ram_1r1w_fwft;

    logic       clk = 1'b0;
    logic       rst, clear, wen, ren, errInj;
    logic [7:0] wdata;
    logic [3:0] afullThresh, aemptyThresh;

    logic [7:0] fwRdata, rgRdata;
    logic       fwRvalid, fwRerr, fwEmpty, fwFull, fwAfull, fwAempty, fwUnder, fwOver, fwSticky;
    logic       rgRvalid, rgRerr, rgEmpty, rgFull, rgAfull, rgAempty, rgUnder, rgOver, rgSticky;
    logic [3:0] fwUsed, fwFree, rgUsed, rgFree;

    int checks = 0;
    int errors = 0;
    logic [7:0] model[$];
    logic [7:0] v;

    always #5 clk = ~clk;

    nx_fifo_ram_1r1w_fwft #(.DATA_W(8), .DEPTH(8), .FWFT(1), .PARITY_EN(1)) u_fwft (
        .clk(clk), .rst(rst), .clear(clear), .wen(wen), .wdata(wdata), .err_inj(errInj),
        .ren(ren), .rdata(fwRdata), .rvalid(fwRvalid), .rerr(fwRerr), .empty(fwEmpty),
        .full(fwFull), .used_slots(fwUsed), .free_slots(fwFree), .afull_thresh(afullThresh),
        .aempty_thresh(aemptyThresh), .afull(fwAfull), .aempty(fwAempty),
        .underflow(fwUnder), .overflow(fwOver), .parity_err_sticky(fwSticky)
    );

    nx_fifo_ram_1r1w_fwft #(.DATA_W(8), .DEPTH(8), .FWFT(0), .PARITY_EN(1)) u_reg (
        .clk(clk), .rst(rst), .clear(clear), .wen(wen), .wdata(wdata), .err_inj(errInj),
        .ren(ren), .rdata(rgRdata), .rvalid(rgRvalid), .rerr(rgRerr), .empty(rgEmpty),
        .full(rgFull), .used_slots(rgUsed), .free_slots(rgFree), .afull_thresh(afullThresh),
        .aempty_thresh(aemptyThresh), .afull(rgAfull), .aempty(rgAempty),
        .underflow(rgUnder), .overflow(rgOver), .parity_err_sticky(rgSticky)
    );

    // Drive one cycle of inputs, let the rising edge take them, then sample 1ns later.
    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic inj,
                                 input logic r, input logic clr);
        wen    = w;
        wdata  = d;
        errInj = inj;
        ren    = r;
        clear  = clr;
        @(posedge clk);
        #1;
        wen    = 1'b0;
        ren    = 1'b0;
        clear  = 1'b0;
        errInj = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".empty"},  32'(fwEmpty),  32'd1);
        checkOutput({tag, ".full"},   32'(fwFull),   32'd0);
        checkOutput({tag, ".used"},   32'(fwUsed),   32'd0);
        checkOutput({tag, ".free"},   32'(fwFree),   32'd8);
        checkOutput({tag, ".rvalid"}, 32'(fwRvalid), 32'd0);
        checkOutput({tag, ".rdata"},  32'(fwRdata),  32'd0);
        checkOutput({tag, ".rerr"},   32'(fwRerr),   32'd0);
        checkOutput({tag, ".afull"},  32'(fwAfull),  32'd0);
        checkOutput({tag, ".aempty"}, 32'(fwAempty), 32'd1);
        checkOutput({tag, ".under"},  32'(fwUnder),  32'd0);
        checkOutput({tag, ".over"},   32'(fwOver),   32'd0);
        checkOutput({tag, ".sticky"}, 32'(fwSticky), 32'd0);
        checkOutput({tag, ".rgEmpty"}, 32'(rgEmpty), 32'd1);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; wen = 1'b0; ren = 1'b0; errInj = 1'b0; wdata = 8'h00;
        afullThresh  = 4'd6;
        aemptyThresh = 4'd1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        checkResetState("init");

        $display("[TB] fwft write latency");
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        checkOutput("lat.rvalidC1", 32'(fwRvalid), 32'd0);
        checkOutput("lat.usedC1",   32'(fwUsed),   32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("lat.rvalidC2", 32'(fwRvalid), 32'd1);
        checkOutput("lat.rdataC2",  32'(fwRdata),  32'hA5);
        checkOutput("lat.usedC2",   32'(fwUsed),   32'd1);
        checkOutput("lat.aempty",   32'(fwAempty), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("lat.emptyAfterPop", 32'(fwEmpty), 32'd1);
        checkOutput("lat.rgRdata",  32'(rgRdata),  32'hA5);

        $display("[TB] fill, overflow and drain");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            checkOutput("fill.afull", 32'(fwAfull), (i + 1 >= 6) ? 32'd1 : 32'd0);
        end
        checkOutput("fill.full", 32'(fwFull), 32'd1);
        checkOutput("fill.free", 32'(fwFree), 32'd0);
        applyStimulus(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        checkOutput("fill.overPulse", 32'(fwOver), 32'd1);
        checkOutput("fill.usedHeld",  32'(fwUsed), 32'd8);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("fill.overEnd",   32'(fwOver), 32'd0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("drain.rvalid", 32'(fwRvalid), 32'd1);
            checkOutput("drain.rdata",  32'(fwRdata),  32'(8'(i)));
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("drain.empty", 32'(fwEmpty), 32'd1);
        checkOutput("drain.used",  32'(fwUsed),  32'd0);

        $display("[TB] registered read mode");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("reg.underPulse", 32'(rgUnder),  32'd1);
        checkOutput("reg.rvalidUf",   32'(rgRvalid), 32'd0);
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        checkOutput("reg.underEnd",   32'(rgUnder),  32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("reg.rvalidIdle", 32'(rgRvalid), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("reg.rvalidN1",   32'(rgRvalid), 32'd1);
        checkOutput("reg.rdataN1",    32'(rgRdata),  32'h3C);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("reg.rvalidN2",   32'(rgRvalid), 32'd0);

        $display("[TB] full with simultaneous read/write and wrap");
        model.delete();
        for (int i = 0; i < 8; i++) begin
            v = 8'(8'h40 + i);
            model.push_back(v);
            applyStimulus(1'b1, v, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("wrap.full",   32'(fwFull),   32'd1);
        checkOutput("wrap.head",   32'(fwRdata),  32'(model[0]));
        applyStimulus(1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
        void'(model.pop_front());
        checkOutput("wrap.used7",  32'(fwUsed),   32'd7);
        checkOutput("wrap.over",   32'(fwOver),   32'd1);
        checkOutput("wrap.rgUsed", 32'(rgUsed),   32'd7);
        checkOutput("wrap.rgOver", 32'(rgOver),   32'd1);
        for (int k = 0; k < 20; k++) begin
            v = 8'(8'h50 + k);
            checkOutput("wrap.rvalid", 32'(fwRvalid), 32'd1);
            checkOutput("wrap.rdata",  32'(fwRdata),  32'(model[0]));
            applyStimulus(1'b1, v, 1'b0, 1'b1, 1'b0);
            void'(model.pop_front());
            model.push_back(v);
            checkOutput("wrap.usedSteady", 32'(fwUsed), 32'd7);
        end

        $display("[TB] reset mid-burst");
        rst = 1'b1;
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        checkResetState("midRst");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("midRst.noPrefetch", 32'(fwRvalid), 32'd0);

        $display("[TB] clear with wen/ren");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("clr.used5",  32'(fwUsed),   32'd5);
        checkOutput("clr.aempty", 32'(fwAempty), 32'd0);
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
        checkOutput("clr.used",   32'(fwUsed),   32'd0);
        checkOutput("clr.empty",  32'(fwEmpty),  32'd1);
        checkOutput("clr.free",   32'(fwFree),   32'd8);
        checkOutput("clr.under",  32'(fwUnder),  32'd0);
        checkOutput("clr.over",   32'(fwOver),   32'd0);
        checkOutput("clr.rgUsed", 32'(rgUsed),   32'd0);
        checkOutput("clr.rgValid", 32'(rgRvalid), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("clr.noLeak", 32'(fwRvalid), 32'd0);
        checkOutput("clr.usedIdle", 32'(fwUsed), 32'd0);

        $display("[TB] parity injection");
        applyStimulus(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        checkOutput("par.rvalid", 32'(fwRvalid), 32'd1);
        checkOutput("par.rdata1", 32'(fwRdata),  32'h11);
        checkOutput("par.rerr1",  32'(fwRerr),   32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("par.sticky", 32'(fwSticky), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("par.rdata2", 32'(fwRdata),  32'h22);
        checkOutput("par.rerr2",  32'(fwRerr),   32'd0);
        checkOutput("par.rgData1", 32'(rgRdata), 32'h11);
        checkOutput("par.rgErr1",  32'(rgRerr),  32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("par.emptyEnd", 32'(fwEmpty), 32'd1);
        checkOutput("par.rgData2",  32'(rgRdata), 32'h22);
        checkOutput("par.rgErr2",   32'(rgRerr),  32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("par.stickyClr", 32'(fwSticky), 32'd1);
        checkOutput("par.rgSticky",  32'(rgSticky), 32'd1);
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("par.stickyRst", 32'(fwSticky), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
